wishbone_arbiter_n: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 28 ++
 rtl/wb_arb_picker.sv | 39 +++
 rtl/wishbone_arbiter_n.sv | 159 +++++++++++++++
 tb/tb_wishbone_arbiter_n.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the N-master Wishbone arbiter.
package wb_arb_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_e;

   localparam int MAX_MASTERS = 8;

   // OR-reduction encoder; the arbiter only ever feeds it a one-hot or zero vector.
   function automatic logic [2:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] onehot);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_MASTERS; i++) begin
         if (onehot[i]) begin
            idx = idx | 3'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/wb_arb_picker.sv
// Combinational winner selection: fixed priority (index 0 first) or
// round-robin starting just after the pointer, with an exclusion mask.
module wb_arb_picker
   import wb_arb_pkg::*;
#(
   parameter int N_MASTERS = 4,
   parameter int PTR_W     = 2
) (
   input  logic [N_MASTERS-1:0] req,
   input  logic [PTR_W-1:0]     ptr,
   input  arb_mode_e            mode,
   input  logic [N_MASTERS-1:0] exclude,
   output logic [N_MASTERS-1:0] winner,
   output logic                 valid
);

   logic [N_MASTERS-1:0] eligible;
   int                   start;
   int                   idx;

   always_comb begin
      winner   = '0;
      valid    = 1'b0;
      eligible = req & ~exclude;
      start    = (mode == ARB_RR) ? int'(ptr) + 1 : 0;
      idx      = 0;
      for (int k = 0; k < N_MASTERS; k++) begin
         idx = start + k;
         if (idx >= N_MASTERS) begin
            idx = idx - N_MASTERS;
         end
         if (!valid && eligible[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wishbone_arbiter_n.sv
// N-master to 1-slave pipelined Wishbone arbiter with bus locking for the whole cyc tenure.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that errors out and evicts a master left without ack.
module wishbone_arbiter_n
   import wb_arb_pkg::*;
#(
   parameter int N_MASTERS = 4,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int ARB_MODE  = 1,
   parameter int TIMEOUT   = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_MASTERS*ADDR_W-1:0] m_adr,
   input  logic [N_MASTERS*DATA_W-1:0] m_dat_w,
   input  logic [N_MASTERS-1:0]        m_we,
   input  logic [N_MASTERS-1:0]        m_stb,
   input  logic [N_MASTERS-1:0]        m_cyc,
   output logic [DATA_W-1:0]           m_dat_r,
   output logic [N_MASTERS-1:0]        m_ack,
   output logic [N_MASTERS-1:0]        m_stall,
   output logic [N_MASTERS-1:0]        m_err,
   output logic [ADDR_W-1:0]           s_adr,
   output logic [DATA_W-1:0]           s_dat_w,
   output logic                        s_we,
   output logic                        s_stb,
   output logic                        s_cyc,
   input  logic [DATA_W-1:0]           s_dat_r,
   input  logic                        s_ack,
   input  logic                        s_stall,
   output logic [N_MASTERS-1:0]        grant
);

   localparam int        PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam arb_mode_e MODE  = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

   if (N_MASTERS < 2 || N_MASTERS > MAX_MASTERS || TIMEOUT < 2) begin : g_bad_cfg
      $error("wishbone_arbiter_n: N_MASTERS must be 2..8 and TIMEOUT >= 2");
   end

   state_e                 state;
   state_e                 state_nxt;
   logic [N_MASTERS-1:0]   grant_nxt;
   logic [PTR_W-1:0]       ptr;
   logic [PTR_W-1:0]       ptr_nxt;
   logic [N_MASTERS-1:0]   winner;
   logic [MAX_MASTERS-1:0] winner_wide;
   logic                   win_valid;
   logic                   owner_cyc;
   logic                   ack_routed;
   logic                   timeout_hit;

   // The current owner is always excluded, so a release or eviction hands over to someone else.
   wb_arb_picker #(
      .N_MASTERS(N_MASTERS),
      .PTR_W    (PTR_W)
   ) u_picker (
      .req    (m_cyc),
      .ptr    (ptr),
      .mode   (MODE),
      .exclude(grant),
      .winner (winner),
      .valid  (win_valid)
   );

   assign owner_cyc  = |(m_cyc & grant);
   assign ack_routed = s_ack & owner_cyc;

   always_comb begin
      winner_wide                = '0;
      winner_wide[N_MASTERS-1:0] = winner;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= PTR_W'(N_MASTERS - 1);
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (win_valid) begin
               state_nxt = OWNED;
               grant_nxt = winner;
               ptr_nxt   = PTR_W'(onehot_to_idx(winner_wide));
            end
         end
         OWNED: begin
            if (!owner_cyc || timeout_hit) begin
               if (win_valid) begin
                  grant_nxt = winner;
                  ptr_nxt   = PTR_W'(onehot_to_idx(winner_wide));
               end else begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT);

   logic [CNT_W-1:0] wd_cnt;

   assign timeout_hit = (state == OWNED) && (wd_cnt == CNT_W'(TIMEOUT - 1));
   assign m_err       = timeout_hit ? grant : '0;

   // Every grant change (new owner or drop to idle) restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if ((grant_nxt != grant) || ack_routed) begin
         wd_cnt <= '0;
      end else if (state == OWNED) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign m_err       = '0;
`endif

   always_comb begin
      s_adr   = '0;
      s_dat_w = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (grant[i]) begin
            s_adr   = s_adr | m_adr[i*ADDR_W +: ADDR_W];
            s_dat_w = s_dat_w | m_dat_w[i*DATA_W +: DATA_W];
         end
      end
   end

   assign s_we  = |(m_we & grant);
   assign s_stb = |(m_stb & grant) & ~timeout_hit;
   assign s_cyc = owner_cyc & ~timeout_hit;

   // Acks are only forwarded while the owner still holds cyc; late acks are dropped.
   assign m_ack   = ack_routed ? grant : '0;
   assign m_stall = s_stall ? '1 : ~grant;
   assign m_dat_r = s_dat_r;

endmodule

// File: tb/tb_wishbone_arbiter_n.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share one stimulus,
// each compared every cycle against an integer-level ownership model.
module tb_wishbone_arbiter_n;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 8;

   logic            clk;
   logic            rst_n;
   logic [N*AW-1:0] m_adr;
   logic [N*DW-1:0] m_dat_w;
   logic [N-1:0]    m_we;
   logic [N-1:0]    m_stb;
   logic [N-1:0]    m_cyc;
   logic [DW-1:0]   s_dat_r;
   logic            s_ack;
   logic            s_stall;

   // index 0 = round-robin instance, index 1 = fixed-priority instance
   logic [DW-1:0] m_dat_r [2];
   logic [N-1:0]  m_ack   [2];
   logic [N-1:0]  m_stall [2];
   logic [N-1:0]  m_err   [2];
   logic [N-1:0]  grant   [2];
   logic [AW-1:0] s_adr   [2];
   logic [DW-1:0] s_dat_w [2];
   logic          s_we    [2];
   logic          s_stb   [2];
   logic          s_cyc   [2];

   int owner [2];
   int last  [2];
   int wd    [2];
   int total;
   int bad;

   logic [N-1:0] e;
   logic [N-1:0] cur;

   wishbone_arbiter_n #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(TO)) dut_rr (
      .clk(clk), .rst_n(rst_n), .m_adr(m_adr), .m_dat_w(m_dat_w), .m_we(m_we), .m_stb(m_stb),
      .m_cyc(m_cyc), .m_dat_r(m_dat_r[0]), .m_ack(m_ack[0]), .m_stall(m_stall[0]), .m_err(m_err[0]),
      .s_adr(s_adr[0]), .s_dat_w(s_dat_w[0]), .s_we(s_we[0]), .s_stb(s_stb[0]), .s_cyc(s_cyc[0]),
      .s_dat_r(s_dat_r), .s_ack(s_ack), .s_stall(s_stall), .grant(grant[0])
   );

   wishbone_arbiter_n #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(TO)) dut_fixed (
      .clk(clk), .rst_n(rst_n), .m_adr(m_adr), .m_dat_w(m_dat_w), .m_we(m_we), .m_stb(m_stb),
      .m_cyc(m_cyc), .m_dat_r(m_dat_r[1]), .m_ack(m_ack[1]), .m_stall(m_stall[1]), .m_err(m_err[1]),
      .s_adr(s_adr[1]), .s_dat_w(s_dat_w[1]), .s_we(s_we[1]), .s_stb(s_stb[1]), .s_cyc(s_cyc[1]),
      .s_dat_r(s_dat_r), .s_ack(s_ack), .s_stall(s_stall), .grant(grant[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   // Next owner by policy: round-robin walks upward from the last winner, fixed walks from 0.
   function automatic int pickModel(input int d, input logic [N-1:0] req, input int excl);
      int i;
      for (int k = 0; k < N; k++) begin
         i = (d == 0) ? (last[d] + 1 + k) % N : k;
         if (req[i] && i != excl) return i;
      end
      return -1;
   endfunction

   function automatic logic timedOut(input int d);
`ifdef WB_ARB_TIMEOUT_EN
      return (owner[d] >= 0) && (wd[d] == TO - 1);
`else
      return 1'b0;
`endif
   endfunction

   task automatic resetModel();
      for (int d = 0; d < 2; d++) begin
         owner[d] = -1;
         last[d]  = N - 1;
         wd[d]    = 0;
      end
   endtask

   task automatic updateModel();
      int w;
      logic to;
      if (!rst_n) begin
         resetModel();
         return;
      end
      for (int d = 0; d < 2; d++) begin
         to = timedOut(d);
         if (owner[d] < 0) begin
            w = pickModel(d, m_cyc, -1);
            if (w >= 0) begin
               owner[d] = w; last[d] = w; wd[d] = 0;
            end
         end else if (m_cyc[owner[d]] && !to) begin
            wd[d] = s_ack ? 0 : wd[d] + 1;
         end else begin
            w = pickModel(d, m_cyc, owner[d]);
            if (w >= 0) begin
               owner[d] = w; last[d] = w; wd[d] = 0;
            end else begin
               owner[d] = -1; wd[d] = 0;
            end
         end
      end
   endtask

   task automatic checkModel();
      logic [N-1:0]  g, ack, stall, err;
      logic          exp_cyc, exp_stb, exp_we, to;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      int            o;
      string         nm;
      for (int d = 0; d < 2; d++) begin
         o  = rst_n ? owner[d] : -1;
         to = rst_n ? timedOut(d) : 1'b0;
         nm = (d == 0) ? "rr" : "fixed";
         g = '0; exp_cyc = 1'b0; exp_stb = 1'b0; exp_we = 1'b0; adr = '0; dat = '0; ack = '0;
         if (o >= 0) begin
            g[o]    = 1'b1;
            exp_cyc = m_cyc[o] & ~to;
            exp_stb = m_stb[o] & ~to;
            exp_we  = m_we[o];
            adr     = m_adr[o*AW +: AW];
            dat     = m_dat_w[o*DW +: DW];
            if (s_ack && m_cyc[o]) ack = g;
         end
         stall = s_stall ? '1 : ~g;
         err   = to ? g : '0;
         checkOutput({nm, ".grant"}, grant[d], g);
         checkOutput({nm, ".s_cyc"}, s_cyc[d], exp_cyc);
         checkOutput({nm, ".s_stb"}, s_stb[d], exp_stb);
         checkOutput({nm, ".s_we"}, s_we[d], exp_we);
         checkOutput({nm, ".s_adr"}, s_adr[d], adr);
         checkOutput({nm, ".s_dat_w"}, s_dat_w[d], dat);
         checkOutput({nm, ".m_ack"}, m_ack[d], ack);
         checkOutput({nm, ".m_stall"}, m_stall[d], stall);
         checkOutput({nm, ".m_err"}, m_err[d], err);
         checkOutput({nm, ".m_dat_r"}, m_dat_r[d], s_dat_r);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] cyc, input logic [N-1:0] stb,
                                input logic ack, input logic stall);
      m_cyc   = cyc;
      m_stb   = stb;
      s_ack   = ack;
      s_stall = stall;
   endtask

   task automatic randomizeData();
      m_adr   = {$urandom, $urandom};
      m_dat_w = {$urandom, $urandom, $urandom, $urandom};
      m_we    = 4'($urandom);
      s_dat_r = $urandom;
   endtask

   task automatic sampleCycle();
      @(negedge clk);
      checkModel();
   endtask

   task automatic advance();
      @(posedge clk);
      updateModel();
      #1;
   endtask

   task automatic resetDut();
      applyStimulus('0, '0, 1'b0, 1'b0);
      rst_n = 1'b0;
      resetModel();
      #1;
      checkModel();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      applyStimulus('0, '0, 1'b0, 1'b0);
      randomizeData();
      resetModel();

      // reset values
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checkOutput("reset.grant", grant[d], 4'b0000);
         checkOutput("reset.s_cyc", s_cyc[d], 1'b0);
         checkOutput("reset.m_ack", m_ack[d], 4'b0000);
         checkOutput("reset.m_stall", m_stall[d], 4'b1111);
         checkOutput("reset.m_err", m_err[d], 4'b0000);
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // single request from idle, then a 3-cycle slave stall
      applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0);
      sampleCycle();
      checkOutput("single.idle_scyc", s_cyc[0], 1'b0);
      advance();
      sampleCycle();
      checkOutput("single.scyc", s_cyc[0], 1'b1);
      checkOutput("single.stall", m_stall[0], 4'b1101);
      checkOutput("single.noack", m_ack[0], 4'b0000);
      advance();
      applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0);
      sampleCycle();
      checkOutput("single.ack", m_ack[0], 4'b0010);
      advance();
      for (int n = 0; n < 3; n++) begin
         applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b1);
         sampleCycle();
         checkOutput("stall.m_stall", m_stall[0], 4'b1111);
         checkOutput("stall.adr", s_adr[0], m_adr[AW +: AW]);
         advance();
      end
      applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0);
      sampleCycle();
      checkOutput("stall.release", m_stall[0], 4'b1101);
      advance();
      applyStimulus('0, '0, 1'b0, 1'b0);
      sampleCycle();
      advance();

      // round-robin rotation with everyone requesting
      resetDut();
      applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0);
      sampleCycle();
      checkOutput("rr_seq.idle", grant[0], 4'b0000);
      advance();
      for (int k = 0; k < 5; k++) begin
         e = 4'b0001 << (k % N);
         applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0);
         sampleCycle();
         checkOutput($sformatf("rr_seq%0d", k), grant[0], e);
         advance();
         applyStimulus(~e, ~e, 1'b0, 1'b0);
         sampleCycle();
         checkOutput($sformatf("rr_hold%0d", k), grant[0], e);
         advance();
      end
      applyStimulus('0, '0, 1'b0, 1'b0);
      sampleCycle();
      advance();

      // fixed priority: no preemption, back-to-back handover
      applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0);
      sampleCycle();
      advance();
      for (int n = 0; n < 3; n++) begin
         applyStimulus(4'b0101, 4'b0100, 1'b0, 1'b0);
         sampleCycle();
         checkOutput("fixed.hold", grant[1], 4'b0100);
         advance();
      end
      applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
      sampleCycle();
      checkOutput("fixed.release", grant[1], 4'b0100);
      advance();
      sampleCycle();
      checkOutput("fixed.handover", grant[1], 4'b0001);
      advance();
      applyStimulus('0, '0, 1'b0, 1'b0);
      sampleCycle();
      advance();

      // asynchronous reset while master 3 owns the bus and an ack arrives
      resetDut();
      applyStimulus(4'b1000, 4'b1000, 1'b0, 1'b0);
      sampleCycle();
      advance();
      applyStimulus(4'b1111, 4'b1000, 1'b1, 1'b0);
      sampleCycle();
      #1 rst_n = 1'b0;
      resetModel();
      #1;
      checkOutput("rst.grant", grant[0], 4'b0000);
      checkOutput("rst.m_ack", m_ack[0], 4'b0000);
      checkOutput("rst.s_cyc", s_cyc[0], 1'b0);
      checkOutput("rst.fixed_grant", grant[1], 4'b0000);
      checkModel();
      advance();
      rst_n = 1'b1;
      applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0);
      sampleCycle();
      checkOutput("rst.idle", grant[0], 4'b0000);
      advance();
      sampleCycle();
      checkOutput("rst.rr_first", grant[0], 4'b0001);
      advance();
      applyStimulus('0, '0, 1'b0, 1'b0);
      sampleCycle();
      advance();

`ifdef WB_ARB_TIMEOUT_EN
      // watchdog evicts master 1 after TO cycles without ack
      resetDut();
      applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0);
      sampleCycle();
      advance();
      for (int n = 1; n <= TO; n++) begin
         applyStimulus(4'b0110, 4'b0010, 1'b0, 1'b0);
         sampleCycle();
         checkOutput($sformatf("wdog.err%0d", n), m_err[0], (n == TO) ? 4'b0010 : 4'b0000);
         checkOutput($sformatf("wdog.scyc%0d", n), s_cyc[0], (n == TO) ? 1'b0 : 1'b1);
         advance();
      end
      sampleCycle();
      checkOutput("wdog.regrant", grant[0], 4'b0100);
      checkOutput("wdog.regrant_fixed", grant[1], 4'b0100);
      advance();
      applyStimulus('0, '0, 1'b0, 1'b0);
      sampleCycle();
      advance();
`endif

      // randomized traffic with sticky cyc requests
      resetDut();
      cur = '0;
      for (int c = 0; c < 1500; c++) begin
         if (c == 750) begin
            resetDut();
         end
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
         end
         randomizeData();
         applyStimulus(cur, cur & 4'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
         sampleCycle();
         advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
